// File: rtl/piso_pkg.sv
// Shared types and parameter limits for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 64;
    localparam int unsigned LANES_MIN = 1;
    localparam int unsigned LANES_MAX = 8;

endpackage

// File: rtl/piso_tx_if.sv
// Word handshake plus serial line bundle between a word source and piso_tx.
interface piso_tx_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 1
);
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH*LANES-1:0]   in_data;
    logic [LANES-1:0]         ser_data;
    logic                     ser_frame;
    logic                     ser_active;
    logic                     word_done;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_data, ser_frame, ser_active, word_done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_data, ser_frame, ser_active, word_done
    );
endinterface

// File: rtl/piso_lane.sv
// One serial lane: WIDTH-bit shift register with a registered line output.
module piso_lane #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             bit_out
);

    logic [WIDTH-1:0] sr;

    // bit_out is loaded one position ahead of sr so the line stays registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            bit_out <= IDLE_BIT;
        end else if (load) begin
            sr      <= data;
            bit_out <= MSB_FIRST ? data[WIDTH-1] : data[0];
        end else if (shift) begin
            sr      <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
            bit_out <= MSB_FIRST ? sr[WIDTH-2] : sr[1];
        end else begin
            bit_out <= IDLE_BIT;
        end
    end

endmodule

// File: rtl/piso_tx.sv
// Multi-lane parallel-in serial-out transmitter: shared FSM, bit counter and handshake.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);

    localparam int unsigned     CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(WIDTH - 2);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || LANES < LANES_MIN || LANES > LANES_MAX) begin : g_param_err
        $error("piso_tx: WIDTH or LANES out of range");
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             xfer;
    logic             shift;
    logic             frame_q;
    logic             active_q;
    logic             done_q;
    logic [LANES-1:0] ser;

    assign last_bit     = (state == SHIFT) && (cnt == LAST);
    assign bus.in_ready = (state == IDLE) || last_bit;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign shift        = (state == SHIFT) && !last_bit;

    // FSM, counter and registered frame/active/done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            frame_q  <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            frame_q <= 1'b0;
            done_q  <= 1'b0;
            if (state == IDLE) begin
                if (xfer) begin
                    state    <= SHIFT;
                    cnt      <= '0;
                    frame_q  <= 1'b1;
                    active_q <= 1'b1;
                end
            end else if (last_bit) begin
                cnt <= '0;
                if (xfer) begin
                    frame_q <= 1'b1;
                end else begin
                    state    <= IDLE;
                    active_q <= 1'b0;
                end
            end else begin
                cnt    <= cnt + CNT_W'(1);
                done_q <= (cnt == LAST_M1);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        piso_lane #(
            .WIDTH     (WIDTH),
            .MSB_FIRST (MSB_FIRST),
            .IDLE_BIT  (IDLE_BIT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load    (xfer),
            .shift   (shift),
            .data    (bus.in_data[WIDTH*i +: WIDTH]),
            .bit_out (ser[i])
        );
    end

    assign bus.ser_data   = ser;
    assign bus.ser_frame  = frame_q;
    assign bus.ser_active = active_q;
    assign bus.word_done  = done_q;

    a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= LAST);

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: two configurations checked every cycle against a queue-based model.
module tb_piso_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // d0: 16-bit, 1 lane, MSB first, idle 0.  d1: 12-bit, 2 lanes, LSB first, idle 1.
    piso_tx_if #(.WIDTH(16), .LANES(1)) bus0 ();
    piso_tx_if #(.WIDTH(12), .LANES(2)) bus1 ();

    piso_tx #(.WIDTH(16), .LANES(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0));
    piso_tx #(.WIDTH(12), .LANES(2), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Model: one queue entry per upcoming output cycle; front entry is what the lines show now.
    typedef struct {
        logic [1:0] d;
        bit         f;
        bit         dn;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    ent_t e;
    bit   x0, x1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            x0 = bus0.in_valid && (q0.size() <= 1);
            x1 = bus1.in_valid && (q1.size() <= 1);
            if (q0.size() != 0) void'(q0.pop_front());
            if (q1.size() != 0) void'(q1.pop_front());
            if (x0) begin
                for (int k = 0; k < 16; k++) begin
                    e.d  = {1'b0, bus0.in_data[15-k]};
                    e.f  = (k == 0);
                    e.dn = (k == 15);
                    q0.push_back(e);
                end
            end
            if (x1) begin
                for (int k = 0; k < 12; k++) begin
                    e.d  = {bus1.in_data[12+k], bus1.in_data[k]};
                    e.f  = (k == 0);
                    e.dn = (k == 11);
                    q1.push_back(e);
                end
            end
        end
    end

    bit stop_chk = 1'b0;

    // Per-cycle compare of both DUTs against the model
    always @(negedge clk) begin
        if (!stop_chk) begin
            chk("d0_data",   bus0.ser_data,   (q0.size() != 0) ? 64'(q0[0].d[0]) : 64'(0));
            chk("d0_frame",  bus0.ser_frame,  (q0.size() != 0) ? 64'(q0[0].f)    : 64'(0));
            chk("d0_done",   bus0.word_done,  (q0.size() != 0) ? 64'(q0[0].dn)   : 64'(0));
            chk("d0_active", bus0.ser_active, 64'(q0.size() != 0));
            chk("d0_ready",  bus0.in_ready,   64'(q0.size() <= 1));
            chk("d1_data",   bus1.ser_data,   (q1.size() != 0) ? 64'(q1[0].d)    : 64'(2'b11));
            chk("d1_frame",  bus1.ser_frame,  (q1.size() != 0) ? 64'(q1[0].f)    : 64'(0));
            chk("d1_done",   bus1.word_done,  (q1.size() != 0) ? 64'(q1[0].dn)   : 64'(0));
            chk("d1_active", bus1.ser_active, 64'(q1.size() != 0));
            chk("d1_ready",  bus1.in_ready,   64'(q1.size() <= 1));
        end
    end

    logic [15:0] v16, f16, d16;
    logic [31:0] v32, f32, r32, a32;
    logic [11:0] l0, l1;
    logic [25:0] a26;

    initial begin
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready0",  bus0.in_ready, 1);
        chk("rst_active0", bus0.ser_active, 0);
        chk("rst_idle1",   bus1.ser_data, 2'b11);
        rst = 1'b0;

        // A5C3, MSB first
        @(negedge clk);
        bus0.in_valid = 1'b1; bus0.in_data = 16'hA5C3;
        v16 = '0; f16 = '0; d16 = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus0.in_valid = 1'b0;
            v16 = {v16[14:0], bus0.ser_data[0]};
            f16 = {f16[14:0], bus0.ser_frame};
            d16 = {d16[14:0], bus0.word_done};
        end
        chk("a5c3_bits",  v16, 16'hA5C3);
        chk("a5c3_frame", f16, 16'h8000);
        chk("a5c3_done",  d16, 16'h0001);
        @(negedge clk);
        chk("a5c3_idle", {bus0.ser_active, bus0.ser_data}, 0);

        // FFFF then 0000 with in_valid held
        bus0.in_valid = 1'b1; bus0.in_data = 16'hFFFF;
        v32 = '0; f32 = '0; r32 = '0; a32 = '0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            v32 = {v32[30:0], bus0.ser_data[0]};
            f32 = {f32[30:0], bus0.ser_frame};
            r32 = {r32[30:0], bus0.in_ready};
            a32 = {a32[30:0], bus0.ser_active};
            if (k == 0)  bus0.in_data = 16'h0000;
            if (k == 16) bus0.in_valid = 1'b0;
        end
        chk("b2b_bits",   v32, 32'hFFFF_0000);
        chk("b2b_frame",  f32, 32'h8000_8000);
        chk("b2b_ready",  r32, 32'h0001_0001);
        chk("b2b_active", a32, 32'hFFFF_FFFF);
        @(negedge clk);

        // Reset during bit 5, then a fresh word
        bus0.in_valid = 1'b1; bus0.in_data = 16'h1234;
        repeat (4) begin
            @(negedge clk);
            bus0.in_valid = 1'b0;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_active", bus0.ser_active, 0);
        chk("midrst_data",   bus0.ser_data, 0);
        chk("midrst_done",   bus0.word_done, 0);
        @(negedge clk);
        rst = 1'b0;
        bus0.in_valid = 1'b1; bus0.in_data = 16'h8000;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        chk("post_rst_frame", bus0.ser_frame, 1);
        chk("post_rst_bit",   bus0.ser_data, 1);
        repeat (16) @(negedge clk);

        // 12-bit, 2 lanes, LSB first, two back-to-back words
        bus1.in_valid = 1'b1; bus1.in_data = {12'h800, 12'h001};
        l0 = '0; l1 = '0; a26 = '0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            if (k < 12) begin
                l0 = {l0[10:0], bus1.ser_data[0]};
                l1 = {l1[10:0], bus1.ser_data[1]};
            end
            a26 = {a26[24:0], bus1.ser_active};
            if (k == 12) bus1.in_valid = 1'b0;
        end
        chk("w12_lane0",  l0, 12'h800);
        chk("w12_lane1",  l1, 12'h001);
        chk("w12_active", a26, 26'h3FF_FFFC);
        chk("w12_idle",   bus1.ser_data, 2'b11);

        // Randomized traffic on both configurations, with occasional async reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus0.in_valid = ($urandom_range(0, 3) != 0);
            bus0.in_data  = 16'($urandom);
            bus1.in_valid = ($urandom_range(0, 3) != 0);
            bus1.in_data  = 24'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end

        @(negedge clk);
        stop_chk = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 16, bits per word per lane; SHALL be 2..64.
REQ-002 Parameter LANES, default 1, number of parallel serial lanes; SHALL be 1..8.
REQ-003 Parameter MSB_FIRST, default 1; 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-004 Parameter IDLE_BIT, default 0, line level driven on every lane when no word is being sent.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  in_data holds a word to send.
REQ-008 in_ready  output  1  block accepts in_data on this edge when in_valid is also high.
REQ-009 in_data  input  WIDTH*LANES  word; lane i takes slice [WIDTH*i +: WIDTH].
REQ-010 ser_data  output  LANES  serial bit per lane; bit i is lane i.
REQ-011 ser_frame  output  1  high during the first bit of each word.
REQ-012 ser_active  output  1  high while ser_data carries word bits.
REQ-013 word_done  output  1  one-cycle pulse during the last bit of each word.

Function
REQ-014 Two states SHALL exist: IDLE and SHIFT.
REQ-015 in_ready SHALL be combinational: high in IDLE, and high in SHIFT only during the last bit (bit count = WIDTH-1).
REQ-016 Transfer SHALL occur on an edge where in_valid and in_ready are both high; in_data is ignored otherwise.
REQ-017 IDLE plus transfer: load all lane shift registers, clear the bit counter, go to SHIFT. The first bit SHALL appear on ser_data in the cycle after the transfer edge.
REQ-018 ser_data, ser_frame, ser_active and word_done SHALL be driven from registers, with no combinational path from inputs.
REQ-019 In SHIFT, each edge SHALL advance every lane by one bit, in the order set by MSB_FIRST, and increment the counter.
REQ-020 Last bit with a transfer: reload and stay in SHIFT, so the next word's first bit follows with no gap cycle and ser_frame is high again.
REQ-021 Last bit without a transfer: go to IDLE; ser_data = IDLE_BIT on all lanes and ser_active = 0 from the next cycle.
REQ-022 Each word SHALL occupy exactly WIDTH consecutive cycles with ser_active high.
REQ-023 ser_frame SHALL be high only on counter = 0, and word_done only on counter = WIDTH-1.
REQ-024 Bit counter width SHALL be $clog2(WIDTH); the counter SHALL never exceed WIDTH-1, including when WIDTH is not a power of two.
REQ-025 All lanes SHALL shift in lockstep and share one counter and one state machine.

Reset
REQ-026 While rst is high: state = IDLE, counter = 0, shift registers = 0, ser_data = {LANES{IDLE_BIT}}, ser_frame = 0, ser_active = 0, word_done = 0.
REQ-027 in_ready SHALL be high in reset; the block SHALL ignore the handshake while rst is high.
REQ-028 rst asserted mid-word SHALL abort the word at once, with no word_done pulse for it.
REQ-029 The first transfer after reset deassertion SHALL start a fresh word with ser_frame high.

Structure
REQ-030 Package piso_pkg SHALL hold the state typedef (IDLE, SHIFT) and the parameter range-check constants.
REQ-031 Sub-module piso_lane SHALL hold one WIDTH-bit lane register with load/shift controls and MSB_FIRST selection; it SHALL be instantiated LANES times.
REQ-032 The top level SHALL hold the FSM, counter and handshake.

Verification
REQ-033 WIDTH=16, MSB_FIRST=1, word 16'hA5C3 -> ser_data 1010010111000011 over 16 cycles; ser_frame on bit 1; word_done on bit 16; then IDLE_BIT.
REQ-034 in_valid held high, words 16'hFFFF then 16'h0000 -> 32 contiguous bits (16 ones, 16 zeros); ser_frame at bits 1 and 17; in_ready high only in IDLE and during bits 16 and 32.
REQ-035 MSB_FIRST=0, word 16'h0001 -> first bit 1, then 15 zeros; word_done on bit 16.
REQ-036 LANES=2, WIDTH=8, in_data 16'h8001 -> lane0 sends 00000001 and lane1 sends 10000000 in the same cycles; a single ser_frame pulse.
REQ-037 rst pulsed during bit 5 -> ser_data = IDLE_BIT and ser_active = 0 immediately; no word_done; next word 16'h8000 starts with ser_frame and first bit 1.
REQ-038 WIDTH=12: two back-to-back words -> 24 contiguous active cycles and the counter never exceeds 11 (checked by assertion).
